// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: frame/receiver state
// encodings, sync byte, oversample ratio and small helper functions.
package imem_uart_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StLenHi,
    StLenLo,
    StData,
    StCsum,
    StDone,
    StErr
  } frame_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  // Oversample divider, truncated, never below one cycle per tick.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

  // Word count must be non-zero and fit the memory without wrapping.
  function automatic logic len_ok(input logic [15:0] n, input int unsigned aw);
    return (n != 16'd0) && ({16'd0, n} <= (32'd1 << aw));
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-flop input synchroniser and 16x oversampling;
// pulses byte_valid or frame_err for one cycle at the end of each frame.
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TickW = $clog2(OVERSAMPLE);

  logic             sync1_q, sync2_q, prev_q;
  logic [DivW-1:0]  div_q, div_d;
  logic             tick;
  rx_state_e        state_q, state_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  assign tick = (div_q == DivW'(DIV - 1));

  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      RxIdle: begin
        if (prev_q && !sync2_q) begin
          state_d    = RxStart;
          tick_cnt_d = '0;
        end
      end
      RxStart: begin
        if (tick) begin
          if (tick_cnt_q == TickW'(OVERSAMPLE / 2 - 1)) begin
            // Mid start bit: a high line here was a glitch, not a start.
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = sync2_q ? RxIdle : RxData;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      RxData: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == TickW'(OVERSAMPLE - 1)) begin
            shift_d   = {sync2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_d = RxStop;
            end
          end
        end
      end
      RxStop: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == TickW'(OVERSAMPLE - 1)) begin
            valid_d = sync2_q;
            err_d   = !sync2_q;
            state_d = RxIdle;
          end
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      div_q      <= '0;
      state_q    <= RxIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      div_q      <= div_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Receives a framed program image over UART (A5, length, big-endian words, XOR
// checksum) and writes it into instruction memory while holding the CPU.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned AW     = 10
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          rxd,
  input  logic          load_en,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   word_count
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx_byte #(
    .DIV(DIV)
  ) u_rx (
    .clk       (clk),
    .RST       (RST),
    .rxd       (rxd),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  frame_state_e  state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [AW:0]   wc_q, wc_d, wc_inc;
  logic [7:0]    csum_q, csum_d;
  logic [23:0]   asm_q, asm_d;
  logic [1:0]    idx_q, idx_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          active;

  assign wc_inc = wc_q + 1'b1;
  assign active = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wc_d    = wc_q;
    csum_d  = csum_q;
    asm_d   = asm_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (!load_en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StSync;
          wc_d    = '0;
          csum_d  = '0;
          asm_d   = '0;
          idx_d   = '0;
        end
        StSync: begin
          if (byte_valid && byte_data == SYNC_BYTE) state_d = StLenHi;
        end
        StLenHi: begin
          if (byte_valid) begin
            len_d   = {byte_data, len_q[7:0]};
            state_d = StLenLo;
          end
        end
        StLenLo: begin
          if (byte_valid) begin
            len_d   = {len_q[15:8], byte_data};
            state_d = len_ok({len_q[15:8], byte_data}, AW) ? StData : StErr;
          end
        end
        StData: begin
          if (byte_valid) begin
            csum_d = csum_q ^ byte_data;
            idx_d  = idx_q + 1'b1;
            if (idx_q == 2'd3) begin
              we_d    = 1'b1;
              addr_d  = wc_q[AW-1:0];
              wdata_d = {asm_q, byte_data};
              wc_d    = wc_inc;
              if (32'(wc_inc) == {16'd0, len_q}) state_d = StCsum;
            end else begin
              asm_d = {asm_q[15:0], byte_data};
            end
          end
        end
        StCsum: begin
          if (byte_valid) state_d = (byte_data == csum_q) ? StDone : StErr;
        end
        default: state_d = state_q;
      endcase
      if (frame_err && active) state_d = StErr;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      len_q   <= '0;
      wc_q    <= '0;
      csum_q  <= '0;
      asm_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wc_q    <= wc_d;
      csum_q  <= csum_d;
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // The CPU stays held after an error so a corrupt image never runs.
  assign cpu_hold   = (state_q != StIdle) && (state_q != StDone);
  assign load_done  = (state_q == StDone);
  assign load_err   = (state_q == StErr);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: table vectors, hand-written corner
// sequences and random frames checked against a byte-stream reference model.
module tb_imem_uart_loader;

  localparam int unsigned CLK_HZ = 1600000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned AW     = 10;
  localparam int          GAP    = 3;

  logic          clk = 1'b0;
  logic          RST;
  logic          rxd;
  logic          load_en;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  imem_uart_loader #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .rxd       (rxd),
    .load_en   (load_en),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  typedef struct {
    logic [95:0] bytes;  // right-aligned, first byte sent is the most significant used
    int          nb;
    bit          done;
    bit          err;
    int          wc;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  int      n_checks = 0;
  int      n_pass   = 0;
  word_q_t wr_data;
  int      wr_addr[$];
  bit      we_twice = 1'b0;
  logic    we_prev  = 1'b0;
  byte_q_t bq;
  int      base;
  vec_t    vecs[6];

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_data.push_back(imem_wdata);
      wr_addr.push_back(int'(imem_addr));
      if (we_prev === 1'b1) we_twice = 1'b1;
    end
    we_prev = imem_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (16) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_all(input byte_q_t q);
    foreach (q[i]) send_byte(q[i], 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic arm(output int b);
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    b = wr_data.size();
    load_en = 1'b1;
    @(negedge clk);
  endtask

  // Reference: parse the byte stream by the frame rules.
  task automatic model(input byte_q_t q, output bit done, output bit err, output int wc,
                       output word_q_t words);
    int          i;
    int          n;
    logic [7:0]  x;
    done  = 1'b0;
    err   = 1'b0;
    wc    = 0;
    words = {};
    x     = 8'h00;
    i     = 0;
    while (i < q.size() && q[i] != 8'hA5) i++;
    i++;
    if (i + 2 > q.size()) return;
    n = int'({q[i], q[i+1]});
    i += 2;
    if (n == 0 || n > (1 << AW)) begin
      err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (i + 4 > q.size()) return;
      words.push_back({q[i], q[i+1], q[i+2], q[i+3]});
      x = x ^ q[i] ^ q[i+1] ^ q[i+2] ^ q[i+3];
      wc++;
      i += 4;
    end
    if (i >= q.size()) return;
    if (q[i] == x) done = 1'b1;
    else err = 1'b1;
  endtask

  task automatic check_model(input string tag, input byte_q_t q, input int b);
    bit      done;
    bit      err;
    int      wc;
    word_q_t words;
    model(q, done, err, wc, words);
    check({tag, " done"}, 32'(load_done), 32'(done));
    check({tag, " err"}, 32'(load_err), 32'(err));
    check({tag, " hold"}, 32'(cpu_hold), 32'(!done));
    check({tag, " word_count"}, 32'(word_count), 32'(wc));
    check({tag, " nwrites"}, 32'(wr_data.size() - b), 32'(words.size()));
    foreach (words[k]) begin
      if (b + k < wr_data.size()) begin
        check($sformatf("%s wdata%0d", tag, k), wr_data[b+k], words[k]);
        check($sformatf("%s addr%0d", tag, k), 32'(wr_addr[b+k]), 32'(k));
      end
    end
  endtask

  initial begin
    RST     = 1'b0;
    rxd     = 1'b1;
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst imem_we", 32'(imem_we), 0);
    check("rst imem_addr", 32'(imem_addr), 0);
    check("rst imem_wdata", imem_wdata, 0);
    check("rst cpu_hold", 32'(cpu_hold), 0);
    check("rst load_done", 32'(load_done), 0);
    check("rst load_err", 32'(load_err), 0);
    check("rst word_count", 32'(word_count), 0);
    RST = 1'b1;
    repeat (2) @(negedge clk);

    vecs[0] = '{96'hA5_00_02_12_34_56_78_9A_BC_DE_F0_00, 12, 1'b1, 1'b0, 2,
                32'h12345678, 32'h9ABCDEF0};
    vecs[1] = '{96'hA5_00_02_12_34_56_78_9A_BC_DE_F0_09, 12, 1'b0, 1'b1, 2,
                32'h12345678, 32'h9ABCDEF0};
    vecs[2] = '{96'hFF_00_A5_00_01_00_00_00_20_20, 10, 1'b1, 1'b0, 1, 32'h00000020, 32'h0};
    vecs[3] = '{96'hA5_00_00, 3, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[4] = '{96'hA5_04_01, 3, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[5] = '{96'hA5_A5_00, 3, 1'b0, 1'b1, 0, 32'h0, 32'h0};

    for (int v = 0; v < 6; v++) begin
      bq = {};
      for (int i = 0; i < vecs[v].nb; i++) bq.push_back(vecs[v].bytes[8*(vecs[v].nb-1-i) +: 8]);
      arm(base);
      send_all(bq);
      check($sformatf("vec%0d done", v), 32'(load_done), 32'(vecs[v].done));
      check($sformatf("vec%0d err", v), 32'(load_err), 32'(vecs[v].err));
      check($sformatf("vec%0d hold", v), 32'(cpu_hold), 32'(!vecs[v].done));
      check($sformatf("vec%0d word_count", v), 32'(word_count), 32'(vecs[v].wc));
      check($sformatf("vec%0d nwrites", v), 32'(wr_data.size() - base), 32'(vecs[v].wc));
      if (vecs[v].wc >= 1 && wr_data.size() > base)
        check($sformatf("vec%0d word0", v), wr_data[base], vecs[v].w0);
      if (vecs[v].wc >= 2 && wr_data.size() > base + 1) begin
        check($sformatf("vec%0d word1", v), wr_data[base+1], vecs[v].w1);
        check($sformatf("vec%0d addr1", v), 32'(wr_addr[base+1]), 1);
      end
    end

    // Stop bit low on the second data byte.
    arm(base);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    repeat (4) @(negedge clk);
    check("framing load_err", 32'(load_err), 1);
    check("framing load_done", 32'(load_done), 0);
    check("framing hold", 32'(cpu_hold), 1);
    check("framing nwrites", 32'(wr_data.size() - base), 0);

    // Abort mid-DATA after one word.
    arm(base);
    send_all('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A});
    check("abort pre nwrites", 32'(wr_data.size() - base), 1);
    load_en = 1'b0;
    @(negedge clk);
    check("abort hold", 32'(cpu_hold), 0);
    check("abort err", 32'(load_err), 0);
    check("abort done", 32'(load_done), 0);
    send_all('{8'hBC, 8'hDE, 8'hF0, 8'h00});
    check("abort post nwrites", 32'(wr_data.size() - base), 1);
    check("abort word_count", 32'(word_count), 1);

    // Reset during DATA; a fresh sync byte is required afterwards.
    arm(base);
    send_all('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56});
    RST = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst hold", 32'(cpu_hold), 0);
    check("midrst word_count", 32'(word_count), 0);
    RST = 1'b1;
    @(negedge clk);
    base = wr_data.size();
    send_all('{8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00});
    check("midrst tail nwrites", 32'(wr_data.size() - base), 0);
    check("midrst tail done", 32'(load_done), 0);
    bq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
           8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
    send_all(bq);
    check_model("midrst resend", bq, base);
    check("midrst resend word0", (wr_data.size() > base) ? wr_data[base] : 32'hx, 32'h12345678);

    // Random frames against the reference model.
    for (int r = 0; r < 6; r++) begin
      int         nj;
      int         n;
      logic [7:0] x;
      logic [7:0] b;
      bq = {};
      nj = int'($urandom_range(0, 2));
      repeat (nj) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        bq.push_back(b);
      end
      bq.push_back(8'hA5);
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3));
      bq.push_back(8'(n >> 8));
      bq.push_back(8'(n));
      x = 8'h00;
      for (int k = 0; k < 4 * n; k++) begin
        b = 8'($urandom);
        x = x ^ b;
        bq.push_back(b);
      end
      if (n != 0) bq.push_back(($urandom_range(0, 1) == 1) ? x : x ^ 8'(1 << $urandom_range(0, 7)));
      arm(base);
      send_all(bq);
      check_model($sformatf("rnd%0d", r), bq, base);
    end

    check("we single-cycle", 32'(we_twice), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
